// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue controller: FSM state encoding
// and default parameter constants.
package mult_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO with wrap-around pointers; each entry holds {A,B}.
// Occupancy and the ready flag are registered so they present clean outputs.
module mult_operand_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [2*WIDTH-1:0]     push_data,
  input  logic                   pop,
  output logic [2*WIDTH-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic               ready_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualified push/pop and next occupancy
  always_comb begin
    do_push_s   = push_valid && ready_r;
    do_pop_s    = pop && (count_r != {CW{1'b0}});
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CW'(DEPTH));
    end
  end

  // Entry storage; contents only matter once written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign push_ready = ready_r;
  assign head_data  = mem_r[rd_ptr_r];
  assign count      = count_r;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues queued operand pairs to a sequential multiplier one at a time,
// captures each product and holds it until the consumer accepts it.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_multiplier,
  input  logic [WIDTH-1:0]       in_multiplicand,
  output logic                   mult_start,
  output logic [WIDTH-1:0]       mult_multiplier,
  output logic [WIDTH-1:0]       mult_multiplicand,
  input  logic [2*WIDTH-1:0]     mult_product,
  input  logic                   mult_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  mult_state_t        state_r;
  logic [TW-1:0]      tcnt_r;
  logic               start_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic               valid_r;
  logic [2*WIDTH-1:0] prod_r;
  logic               busy_r;
  logic               err_r;
  logic [2*WIDTH-1:0] head_s;
  logic               pop_s;

  assign pop_s = (state_r == ST_ISSUE);

  mult_operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({in_multiplier, in_multiplicand}),
    .pop        (pop_s),
    .head_data  (head_s),
    .count      (fill_count)
  );

  // Issue FSM; operands are latched on entry to ISSUE so they are already
  // presented while the start pulse is high, and the head is popped in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      tcnt_r  <= {TW{1'b0}};
      start_r <= 1'b0;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      prod_r  <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((fill_count != {CW{1'b0}}) && !valid_r) begin
            state_r        <= ST_ISSUE;
            start_r        <= 1'b1;
            {opa_r, opb_r} <= head_s;
            busy_r         <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_ARM;
          start_r <= 1'b0;
        end
        ST_ARM: begin
          state_r <= ST_WAIT;
          tcnt_r  <= {TW{1'b0}};
        end
        // A done level seen in ISSUE/ARM is never looked at; only WAIT samples it
        ST_WAIT: begin
          if (mult_done) begin
            state_r <= ST_HOLD;
            prod_r  <= mult_product;
            valid_r <= 1'b1;
          end else if (tcnt_r == TW'(TIMEOUT - 1)) begin
            state_r <= ST_IDLE;
            tcnt_r  <= TW'(TIMEOUT);
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          start_r <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mult_start        = start_r;
  assign mult_multiplier   = opa_r;
  assign mult_multiplicand = opb_r;
  assign out_valid         = valid_r;
  assign out_product       = prod_r;
  assign busy              = busy_r;
  assign timeout_err       = err_r;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mult_issue_ctrl;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_multiplier;
  logic [W-1:0]  in_multiplicand;
  logic          mult_start;
  logic [W-1:0]  mult_multiplier;
  logic [W-1:0]  mult_multiplicand;
  logic [2*W-1:0] mult_product;
  logic          mult_done;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_product;
  logic [2:0]    fill_count;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  mult_issue_ctrl #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_multiplier     (in_multiplier),
    .in_multiplicand   (in_multiplicand),
    .mult_start        (mult_start),
    .mult_multiplier   (mult_multiplier),
    .mult_multiplicand (mult_multiplicand),
    .mult_product      (mult_product),
    .mult_done         (mult_done),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_product       (out_product),
    .fill_count        (fill_count),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 start cycle, 2 arm cycle, 3 waiting for done, 4 result held
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] res_q[$];
  int             ph;
  int             wcnt;
  logic           e_start;
  logic [W-1:0]   e_a;
  logic [W-1:0]   e_b;
  logic           e_valid;
  logic [2*W-1:0] e_prod;
  logic           e_err;
  int             pre_n;
  logic           m_push;
  logic           m_pop;
  logic [2*W-1:0] junk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      res_q.delete();
      ph = 0; wcnt = 0;
      e_start = 1'b0; e_a = '0; e_b = '0;
      e_valid = 1'b0; e_prod = '0; e_err = 1'b0;
    end else begin
      pre_n  = q.size();
      m_push = in_valid && (pre_n < D);
      m_pop  = (ph == 1);
      case (ph)
        0: if (pre_n > 0 && !e_valid) begin
             ph = 1; e_start = 1'b1;
             {e_a, e_b} = q[0];
             res_q.push_back(16'(e_a) * 16'(e_b));
           end
        1: begin ph = 2; e_start = 1'b0; end
        2: begin ph = 3; wcnt = 0; end
        3: if (mult_done) begin
             ph = 4; e_prod = mult_product; e_valid = 1'b1;
           end else begin
             wcnt++;
             if (wcnt == TO) begin
               ph = 0; e_err = 1'b1;
               junk = res_q.pop_front();
             end
           end
        4: if (out_ready) begin
             chk("accept_prod", out_product, res_q.size() > 0 ? res_q.pop_front() : 16'hxxxx);
             ph = 0; e_valid = 1'b0;
           end
        default: ph = 0;
      endcase
      if (m_pop)  junk = q.pop_front();
      if (m_push) q.push_back({in_multiplier, in_multiplicand});
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("start",  mult_start,        e_start);
      chk("opa",    mult_multiplier,   e_a);
      chk("opb",    mult_multiplicand, e_b);
      chk("valid",  out_valid,         e_valid);
      chk("prod",   out_product,       e_prod);
      chk("fill",   fill_count,        q.size());
      chk("ready",  in_ready,          q.size() != D);
      chk("busy",   busy,              ph != 0);
      chk("err",    timeout_err,       e_err);
    end
  end

  // Accepted results and start pulses, in order
  logic [2*W-1:0] acc[$];
  int             nstart = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (mult_start) nstart++;
      if (out_valid && out_ready) acc.push_back(out_product);
    end
  end

  // ---------------- downstream multiplier stand-in ----------------
  // mode 0: done pulse dly cycles after start; 1: done held high; 2: never done
  int             mode = 0;
  int             dly  = 8;
  int             dcnt = 0;
  logic [2*W-1:0] pend;
  initial begin
    mult_done = 1'b0;
    mult_product = '0;
    pend = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dcnt = 0;
        if (mode != 1) mult_done = 1'b0;
      end else begin
        case (mode)
          0: begin
            mult_done = 1'b0;
            if (mult_start) begin
              dcnt = dly;
              pend = 16'(mult_multiplier) * 16'(mult_multiplicand);
            end else if (dcnt > 0) begin
              dcnt--;
              if (dcnt == 0) begin
                mult_done = 1'b1;
                mult_product = pend;
              end
            end
          end
          1: begin
            mult_done = 1'b1;
            if (mult_start) mult_product = 16'(mult_multiplier) * 16'(mult_multiplicand);
          end
          default: mult_done = 1'b0;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_multiplier = a; in_multiplicand = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Wait for a start pulse, then count cycles until out_valid (which=0)
  // or timeout_err (which=1) is seen.
  task automatic lat_from_start(input int which, output int lat);
    int n;
    n = 0;
    while (!mult_start && n < 40) begin @(negedge clk); n++; end
    chk("start_seen", mult_start, 1'b1);
    lat = 0;
    while (((which == 0) ? !out_valid : !timeout_err) && lat < 200) begin
      @(negedge clk); lat++;
    end
    chk("event_seen", (which == 0) ? out_valid : timeout_err, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2*W-1:0] full_exp [5];
  initial begin
    int lat;
    int base;
    int n0;
    int n;
    full_exp = '{16'd15, 16'd2, 16'd6, 16'd12, 16'd20};
    rst = 1'b1; in_valid = 1'b0; in_multiplier = '0; in_multiplicand = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fill",  fill_count, 3'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_start", mult_start, 1'b0);
    chk("rst_err",   timeout_err, 1'b0);
    chk("rst_prod",  out_product, 16'd0);
    chk("rst_opa",   mult_multiplier, 8'd0);
    #1 rst = 1'b0;

    // Single op: 7*9 with done 8 cycles after start
    push1(8'd7, 8'd9);
    lat_from_start(0, lat);
    chk("s1_lat", lat, 9);
    chk("s1_prod", out_product, 16'd63);
    repeat (3) @(negedge clk);
    chk("s1_hold", out_valid, 1'b1);
    accept();
    chk("s1_nstart", nstart, 1);

    // Full FIFO while a result is held unaccepted
    push1(8'd3, 8'd5);
    lat_from_start(0, lat);
    base = acc.size();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_multiplier = W'(i + 1); in_multiplicand = W'(i + 2);
      @(negedge clk);
      if (i == 3) begin
        chk("full_ready", in_ready, 1'b0);
        chk("full_fill4", fill_count, 3'd4);
      end
    end
    in_valid = 1'b0;
    chk("full_fill_after5", fill_count, 3'd4);
    out_ready = 1'b1;
    n = 0;
    while (acc.size() < base + 5 && n < 300) begin @(negedge clk); n++; end
    out_ready = 1'b0;
    chk("full_count", acc.size(), base + 5);
    for (int i = 0; i < 5; i++)
      chk("full_order", (base + i < acc.size()) ? acc[base + i] : 16'hxxxx, full_exp[i]);
    repeat (4) @(negedge clk);
    chk("full_drained", busy, 1'b0);

    // Stale done held high: capture only once WAIT is reached
    mode = 1;
    repeat (2) @(negedge clk);
    push1(8'd11, 8'd13);
    lat_from_start(0, lat);
    chk("stale_lat", lat, 3);
    chk("stale_prod", out_product, 16'd143);
    accept();
    mode = 0;
    repeat (2) @(negedge clk);

    // Backpressure with two pairs queued
    dly = 4;
    in_valid = 1'b1; in_multiplier = 8'd6; in_multiplicand = 8'd7;
    @(negedge clk);
    in_multiplier = 8'd8; in_multiplicand = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    lat_from_start(0, lat);
    chk("bp_lat", lat, 5);
    n0 = nstart;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_stable", out_product, 16'd42);
    end
    chk("bp_nostart", nstart, n0);
    accept();
    lat_from_start(0, lat);
    chk("bp_prod2", out_product, 16'd72);
    accept();

    // Timeout: done never arrives
    mode = 2;
    push1(8'd2, 8'd2);
    lat_from_start(1, lat);
    chk("to_lat", lat, 66);
    chk("to_busy", busy, 1'b0);
    chk("to_novalid", out_valid, 1'b0);
    mode = 0; dly = 3;
    push1(8'd4, 8'd5);
    lat_from_start(0, lat);
    chk("to_next_prod", out_product, 16'd20);
    chk("to_sticky", timeout_err, 1'b1);
    accept();

    // Reset in WAIT with further pairs queued
    dly = 20;
    in_valid = 1'b1; in_multiplier = 8'd9; in_multiplicand = 8'd9;
    @(negedge clk);
    in_multiplier = 8'd1; in_multiplicand = 8'd1;
    @(negedge clk);
    in_multiplier = 8'd2; in_multiplicand = 8'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_busy_before", busy, 1'b1);
    chk("rw_fill_before", fill_count, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("rw_busy",  busy, 1'b0);
    chk("rw_fill",  fill_count, 3'd0);
    chk("rw_ready", in_ready, 1'b1);
    chk("rw_valid", out_valid, 1'b0);
    chk("rw_start", mult_start, 1'b0);
    chk("rw_opa",   mult_multiplier, 8'd0);
    chk("rw_opb",   mult_multiplicand, 8'd0);
    chk("rw_prod",  out_product, 16'd0);
    chk("rw_err",   timeout_err, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("rw_noval", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, operand width; DEPTH, default 4, operand FIFO entries (power of 2, at least 2); TIMEOUT, default 64, maximum cycles from ARM to mult_done.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept a pair.
- in_multiplier  in  WIDTH  operand A.
- in_multiplicand  in  WIDTH  operand B.
- mult_start  out  1  one-cycle start pulse to the downstream sequential multiplier.
- mult_multiplier  out  WIDTH  operand A presented to the multiplier.
- mult_multiplicand  out  WIDTH  operand B presented to the multiplier.
- mult_product  in  2*WIDTH  multiplier result.
- mult_done  in  1  multiplier done flag.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  captured product.
- fill_count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM is not in IDLE.
- timeout_err  out  1  sticky error flag.

Function
REQ-003 A transfer into the FIFO SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
- in_ready = (fill_count != DEPTH).
- An offer while the FIFO is full SHALL be ignored, with no overwrite.
REQ-004 The FIFO SHALL use wrap-around read/write pointers.
- When a push and a pop happen in the same cycle, fill_count SHALL be unchanged.
- Pop order SHALL be FIFO.
REQ-005 The FSM SHALL have the states IDLE, ISSUE, ARM, WAIT and HOLD, with these transitions:
- IDLE -> ISSUE when fill_count>0 and out_valid=0.
- ISSUE -> ARM unconditionally.
- ARM -> WAIT unconditionally.
- WAIT -> HOLD on mult_done=1.
- WAIT -> IDLE on timeout.
- HOLD -> IDLE when out_ready=1.
REQ-006 In ISSUE, mult_start SHALL be 1 for exactly one cycle, and the FIFO head SHALL be popped and latched into the mult_multiplier/mult_multiplicand registers.
REQ-007 mult_multiplier and mult_multiplicand SHALL stay stable from ISSUE until the next ISSUE.
REQ-008 mult_done SHALL be ignored in ISSUE and ARM, so that a done level left over from the previous operation cannot be taken as completion.
REQ-009 On the WAIT -> HOLD edge:
- out_product SHALL capture mult_product.
- out_valid SHALL go 1 in the following cycle.
REQ-010 Result handshake:
- out_valid SHALL stay 1 and out_product SHALL stay stable until a cycle with out_ready=1.
- out_valid SHALL drop on the edge following that cycle.
REQ-011 Latency: from the first start pulse to out_valid SHALL be (cycles until mult_done seen in WAIT) + 1; back-to-back operations SHALL be separated by at least one IDLE cycle.
REQ-012 Timeout:
- A counter SHALL clear in ARM and increment each WAIT cycle.
- If it reaches TIMEOUT without mult_done, timeout_err SHALL set (sticky until rst) and the FSM SHALL return to IDLE with no result produced.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Simultaneous events:
- A push during ISSUE SHALL be accepted, since pop and push are independent.
- An out_ready=1 while out_valid=0 SHALL have no effect.

Reset
REQ-015 Asserting rst SHALL immediately, asynchronously and at any time, force the following values:
- FSM=IDLE.
- FIFO pointers=0.
- fill_count=0.
- in_ready=1.
- mult_start=0.
- mult_multiplier=0 and mult_multiplicand=0.
- out_valid=0 and out_product=0.
- busy=0.
- timeout_err=0.
- timeout counter=0.
REQ-016 A reset during WAIT or HOLD SHALL discard the operation in flight and all FIFO contents; no out_valid SHALL follow.
REQ-017 After rst deasserts, the first push SHALL be accepted on the first rising edge.

Structure
REQ-018 The FSM state encoding and the default parameter constants SHALL reside in the shared package mult_pkg.
REQ-019 The FIFO SHALL be a separate sub-module, mult_operand_fifo, parameterised by WIDTH and DEPTH and storing {A,B}.
REQ-020 The FSM, timeout counter and result register SHALL reside in mult_issue_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single op: push A=8'd7, B=8'd9, with mult_done modelled 8 cycles after start -> one mult_start pulse; out_product=16'd63; out_valid held until out_ready.
- Full FIFO: push 5 pairs with the multiplier stalled -> in_ready=0 after the 4th push; fill_count=4; the 5th pair is not stored; the results then appear in push order.
- Stale done: mult_done held at 1 continuously from the prior op -> no capture in ISSUE/ARM; the capture occurs in WAIT only.
- Backpressure: out_ready=0 for 10 cycles with 2 pairs queued -> no second mult_start until out_valid is accepted; out_product is stable throughout.
- Timeout: mult_done never asserts -> timeout_err=1 after TIMEOUT WAIT cycles; the FSM returns to IDLE; the next pair issues normally.
- Reset in WAIT: rst pulse mid-operation -> all outputs go to their reset values immediately; fill_count=0; no out_valid afterwards.
